// File: rtl/conv_ser_sched.sv
// Serial scheduler: buffers CHANNEL_NUM*MTRX_NUM samples per output pixel, then replays them as one framed burst.
// Optional stall statistics output enabled by defining CONV_SER_SCHED_STATS_EN.
module conv_ser_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int MTRX_NUM    = 8,
  parameter int STRING_LEN  = 224,
  parameter int STRING_NUM  = 224,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef CONV_SER_SCHED_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);
  // Input handshake: a sample moves when in_valid_i and in_ready_o are both high at a rising edge.
  localparam int GROUP  = CHANNEL_NUM * MTRX_NUM;
  localparam int IDX_W  = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int RD_W   = $clog2(GROUP + 1);
  localparam int PIX_W  = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
  localparam int LINE_W = (STRING_NUM > 1) ? $clog2(STRING_NUM) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  WR_LAST   = IDX_W'(GROUP - 1);
  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(GROUP - 1);
  localparam logic [RD_W-1:0]   RD_END    = RD_W'(GROUP);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(STRING_LEN - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(STRING_NUM - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_GAP, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_buf [GROUP];
  logic [IDX_W-1:0]      r_wr;
  logic [RD_W-1:0]       r_rd;
  logic [GAP_W-1:0]      r_gap;
  logic [PIX_W-1:0]      r_pix;
  logic [LINE_W-1:0]     r_line;
  logic                  r_valid, r_sop, r_eop, r_sof, r_eof, r_done;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_accept, w_emit, w_issue_end, w_last_group, w_sop, w_eop;
  logic [IDX_W-1:0]      w_rd_idx;

  assign w_accept     = (r_state == S_FILL) && in_valid_i;
  // ISSUE runs one cycle past the last read so the registered burst finishes before leaving.
  assign w_emit       = (r_state == S_ISSUE) && (r_rd != RD_END);
  assign w_issue_end  = (r_state == S_ISSUE) && (r_rd == RD_END);
  assign w_last_group = (r_pix == PIX_LAST) && (r_line == LINE_LAST);
  assign w_rd_idx     = r_rd[IDX_W-1:0];
  assign w_sop        = w_emit && (r_rd == '0) && (r_pix == '0);
  assign w_eop        = w_emit && (r_rd == RD_LAST) && (r_pix == PIX_LAST);

  always_comb begin
    w_next     = r_state;
    in_ready_o = 1'b0;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_FILL;
      S_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (r_wr == WR_LAST)) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_rd == RD_END) begin
          if (w_last_group)         w_next = S_DONE;
          else if (GAP_CYCLES == 0) w_next = S_FILL;
          else                      w_next = S_GAP;
        end
      end
      S_GAP:   if (r_gap == GAP_LAST) w_next = S_FILL;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_gap   <= '0;
      r_pix   <= '0;
      r_line  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_wr <= (r_wr == WR_LAST) ? '0 : r_wr + 1'b1;
      r_rd  <= w_emit ? r_rd + 1'b1 : '0;
      r_gap <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
      if (w_issue_end) begin
        if (r_pix == PIX_LAST) begin
          r_pix  <= '0;
          r_line <= (r_line == LINE_LAST) ? '0 : r_line + 1'b1;
        end else begin
          r_pix <= r_pix + 1'b1;
        end
      end else if (r_state == S_DONE) begin
        r_pix  <= '0;
        r_line <= '0;
      end
      r_valid <= w_emit;
      r_data  <= w_emit ? r_buf[w_rd_idx] : '0;
      r_sop   <= w_sop;
      r_eop   <= w_eop;
      r_sof   <= w_sop && (r_line == '0);
      r_eof   <= w_eop && (r_line == LINE_LAST);
      r_done  <= (r_state == S_DONE);
    end
  end

  // Buffer contents need no reset: the write pointer decides what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_wr] <= in_data_i;
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign sop_o   = r_sop;
  assign eop_o   = r_eop;
  assign sof_o   = r_sof;
  assign eof_o   = r_eof;
  assign done_o  = r_done;
  assign busy_o  = (r_state != S_IDLE);

`ifdef CONV_SER_SCHED_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_FILL) && !in_valid_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/conv_ser_sched.md
CONV_SER_SCHED -- requirements
Module: conv_ser_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning sample width in bits (signed).
REQ-002 SHALL have parameter CHANNEL_NUM, default 3, meaning input channels per kernel tap.
REQ-003 SHALL have parameter MTRX_NUM, default 8, meaning kernel taps per output pixel.
REQ-004 SHALL have parameter STRING_LEN, default 224, meaning pixels per line.
REQ-005 SHALL have parameter STRING_NUM, default 224, meaning lines per frame.
REQ-006 SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles between groups (0 allowed).
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-009 SHALL have port start_i, input, 1, meaning a one-cycle frame start request.
REQ-010 SHALL have port in_valid_i, input, 1, meaning upstream sample valid.
REQ-011 SHALL have port in_data_i, input, DATA_WIDTH, meaning upstream sample.
REQ-012 SHALL have port in_ready_o, output, 1, meaning the block accepts a sample this cycle.
REQ-013 SHALL have ports valid_o, data_o[DATA_WIDTH], sop_o, eop_o, sof_o and eof_o, all outputs, meaning the serial stream to the convolution engine.
REQ-014 SHALL have port busy_o, output, 1, meaning a frame is in progress.
REQ-015 SHALL have port done_o, output, 1, meaning a one-cycle frame-complete pulse.

Function
REQ-016 SHALL define GROUP = CHANNEL_NUM*MTRX_NUM samples per output pixel, held in an internal GROUP-deep buffer.
REQ-017 SHALL implement the states IDLE, FILL, ISSUE, GAP and DONE; the reset state SHALL be IDLE.
REQ-018 SHALL go IDLE->FILL on start_i; start_i SHALL be ignored in any state other than IDLE.
REQ-019 SHALL, in FILL, drive in_ready_o=1; a sample transfers when in_valid_i and in_ready_o are both 1.
REQ-020 SHALL drive in_ready_o=0 in every state other than FILL.
REQ-021 SHALL go FILL->ISSUE in the cycle after the GROUP-th sample transfers.
REQ-022 SHALL, in ISSUE, emit the buffered samples in arrival order, one per cycle, valid_o=1 for exactly GROUP consecutive cycles with no bubbles.
REQ-023 SHALL register valid_o, data_o and the framing flags, so that valid_o rises in the cycle after ISSUE is entered.
REQ-024 SHALL assert sop_o with the first sample of the first group of each line.
REQ-025 SHALL assert eop_o with the last sample of the last group of each line.
REQ-026 SHALL assert sof_o together with the first sop_o of the frame, and eof_o together with the last eop_o of the frame.
REQ-027 SHALL keep a pixel counter (0..STRING_LEN-1) and a line counter (0..STRING_NUM-1): the pixel counter SHALL increment after each group and wrap to 0 after STRING_LEN-1, and the line counter SHALL increment on that wrap.
REQ-028 SHALL, after ISSUE, go to GAP for GAP_CYCLES cycles and then to FILL; when GAP_CYCLES=0 it SHALL go directly ISSUE->FILL.
REQ-029 SHALL go ISSUE->DONE after the last group of the last line, skipping GAP.
REQ-030 SHALL, in DONE, pulse done_o for one cycle, clear both counters and return to IDLE.
REQ-031 SHALL hold busy_o=1 in every state other than IDLE.
REQ-032 SHALL keep the state unchanged while in_valid_i stays low in FILL (stall); a stall SHALL never produce a partial group on the output.
REQ-033 SHALL hold all outputs at 0 whenever valid_o=0, with data_o also driven to 0.

Reset
REQ-034 SHALL, while reset_n=0 at a clock edge, set the state to IDLE, clear all counters and the buffer pointers, and drive every output to 0.
REQ-035 SHALL, on reset during FILL, ISSUE or GAP, discard the partial group and emit no further framing flags; a new start_i is then required.

Configuration
REQ-036 SHALL, when CONV_SER_SCHED_STATS_EN is defined, add the output stall_cnt_o[31:0], which counts FILL cycles with in_valid_i=0, clears on start_i, saturates at all-ones and resets to 0.
REQ-037 SHALL, when CONV_SER_SCHED_STATS_EN is undefined, have neither the port nor its logic, with all other behaviour identical.

Verification
REQ-038 SHALL cover: CHANNEL_NUM=3, MTRX_NUM=8, STRING_LEN=2, STRING_NUM=2, continuous input, start_i -> 4 bursts of 24 valid_o cycles each; sof_o+sop_o on sample 0; eop_o on samples 47 and 95; eof_o on sample 95; done_o 2 cycles after sample 95.
REQ-039 SHALL cover: input stalled for 10 cycles after 12 samples -> no valid_o until sample 24 is accepted; burst still 24 contiguous cycles; stall_cnt_o=10 with CONV_SER_SCHED_STATS_EN.
REQ-040 SHALL cover: GAP_CYCLES=4 -> exactly 4 cycles with valid_o=0 and in_ready_o=0 between bursts; GAP_CYCLES=0 -> in_ready_o rises the cycle after the burst ends.
REQ-041 SHALL cover: start_i pulsed mid-frame -> ignored; frame completes with exactly 96 samples.
REQ-042 SHALL cover: reset_n low during the 2nd burst -> all outputs 0 the next cycle; no eof_o or done_o; a new start_i gives a full correct frame.
REQ-043 SHALL cover: data pattern 0..95 (signed wrap) -> data_o matches input order exactly.
